// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared widths, opcode field bounds, opcode constants and the
//               fetch-stage state type used by the CPU front end.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Program memory and instruction geometry
  localparam int ADDR_W  = 5;
  localparam int INSTR_W = 32;

  // Opcode field position inside an instruction word
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;

  // Opcode encodings
  localparam logic [4:0] OP_HALT = 5'b11111;
  localparam logic [4:0] OP_LDI  = 5'b10000;
  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_MEM  = 5'b00100;
  localparam logic [4:0] OP_STR  = 5'b11000;

  // Fetch stage state
  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register. Captures a fetched instruction and
//               its address, holds it while decode is stalled, drops it once
//               it has been taken, and can be flushed by a redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg #(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,   // capture i_instr/i_pc this edge
  input  logic               i_hold,   // keep current contents (decode stalled)
  input  logic               i_flush,  // invalidate, highest priority
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [ADDR_W-1:0]  i_pc,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pc
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_pc;

  // Pipeline register: flush beats load; without load, an un-held entry is
  // considered consumed and dropped. Payload is kept on flush/drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (!i_hold) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule : if_id_reg
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetch stage in front of a 32-entry program memory. Owns the
//               PC, captures instructions into IF/ID with a valid/ready
//               handshake, honours branch redirects, stops on HALT and
//               counts captured instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter int         ADDR_W  = cpu_pkg::ADDR_W,
  parameter int         INSTR_W = cpu_pkg::INSTR_W,
  parameter logic [4:0] HALT_OP = cpu_pkg::OP_HALT,
  parameter int         CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  pmem_addr,
  input  logic [INSTR_W-1:0] pmem_data,
  input  logic               br_valid,
  input  logic [ADDR_W-1:0]  br_target,
  input  logic               id_ready,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_cnt
);

  import cpu_pkg::*;

  fetch_state_e       r_state;
  fetch_state_e       w_state_nxt;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  w_pc_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  logic               w_advance;
  logic               w_is_halt;
  logic               w_load;
  logic               w_flush;
  logic               w_valid;

  // Opcode of the word currently returned by program memory
  assign w_is_halt = (pmem_data[OPC_HI:OPC_LO] == HALT_OP);

  // A new fetch can be captured when running and IF/ID is empty or draining
  assign w_advance = (r_state == RUN) && (!w_valid || id_ready);

  // State, PC and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_pc    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state, next-PC and IF/ID control; a redirect overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_flush     = 1'b0;
    if (br_valid) begin
      w_pc_nxt    = br_target;
      w_state_nxt = RUN;
      w_flush     = 1'b1;
    end else if (w_advance) begin
      w_load    = 1'b1;
      w_cnt_nxt = r_cnt + CNT_W'(1);
      if (w_is_halt) begin
        w_state_nxt = HALT;
      end else begin
        w_pc_nxt = r_pc + ADDR_W'(1);
      end
    end
  end

  if_id_reg #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_hold  (!id_ready),
    .i_flush (w_flush),
    .i_instr (pmem_data),
    .i_pc    (r_pc),
    .o_valid (w_valid),
    .o_instr (if_instr),
    .o_pc    (if_pc)
  );

  assign pmem_addr = r_pc;
  assign if_valid  = w_valid;
  assign halted    = (r_state == HALT);
  assign fetch_cnt = r_cnt;

endmodule : instr_fetch_unit
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed bench for instr_fetch_unit with a behavioural
//               reference model and a per-cycle compare process.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [4:0]  pmem_addr;
  logic [31:0] pmem_data;
  logic        br_valid;
  logic [4:0]  br_target;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [4:0]  if_pc;
  logic        halted;
  logic [15:0] fetch_cnt;

  logic [31:0] mem [32];

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          m_pc;
  bit          m_valid;
  logic [31:0] m_instr;
  int          m_ifpc;
  bit          m_halted;
  int          m_cnt;

  instr_fetch_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pmem_addr (pmem_addr),
    .pmem_data (pmem_data),
    .br_valid  (br_valid),
    .br_target (br_target),
    .id_ready  (id_ready),
    .if_valid  (if_valid),
    .if_instr  (if_instr),
    .if_pc     (if_pc),
    .halted    (halted),
    .fetch_cnt (fetch_cnt)
  );

  assign pmem_data = mem[pmem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a redirect wins; otherwise a free slot in RUN takes the word at
  // pc, a taken entry empties the slot, else nothing moves.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 0; m_valid = 0; m_instr = 0; m_ifpc = 0; m_halted = 0; m_cnt = 0;
    end else if (br_valid) begin
      m_pc = int'(br_target); m_valid = 0; m_halted = 0;
    end else if (!m_halted && (!m_valid || id_ready)) begin
      m_instr = mem[m_pc];
      m_ifpc  = m_pc;
      m_valid = 1;
      m_cnt   = (m_cnt + 1) % 65536;
      if (mem[m_pc][31:27] == 5'b11111) m_halted = 1;
      else m_pc = (m_pc + 1) % 32;
    end else if (m_valid && id_ready) begin
      m_valid = 0;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("cyc_pmem_addr", 32'(pmem_addr), 32'(m_pc));
    chk("cyc_if_valid",  32'(if_valid),  32'(m_valid));
    chk("cyc_if_instr",  if_instr,       m_instr);
    chk("cyc_if_pc",     32'(if_pc),     32'(m_ifpc));
    chk("cyc_halted",    32'(halted),    32'(m_halted));
    chk("cyc_fetch_cnt", 32'(fetch_cnt), 32'(m_cnt));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; br_valid = 1'b0; br_target = '0; id_ready = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = 32'h8000_0000 | 32'(i);
    mem[0]  = 32'h8040_0001;
    mem[1]  = 32'h8080_0002;
    mem[2]  = 32'h80C0_0003;
    mem[3]  = 32'hF800_0000;
    mem[12] = 32'hF800_000C;

    // Reset values before any clock edge
    #2;
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_addr",  32'(pmem_addr), 32'd0);
    chk("rst_cnt",   32'(fetch_cnt), 32'd0);
    chk("rst_halt",  32'(halted), 32'd0);

    // Linear fetch up to HALT at 3
    do_reset();
    tick(); chk("lin_pc0", 32'(if_pc), 32'd0); chk("lin_i0", if_instr, 32'h8040_0001);
    tick(); chk("lin_pc1", 32'(if_pc), 32'd1);
    tick(); chk("lin_pc2", 32'(if_pc), 32'd2); chk("lin_addr3", 32'(pmem_addr), 32'd3);
    tick(); chk("lin_pc3", 32'(if_pc), 32'd3); chk("lin_halt", 32'(halted), 32'd1);
    chk("lin_cnt4", 32'(fetch_cnt), 32'd4);
    tick(); chk("lin_drop", 32'(if_valid), 32'd0); chk("lin_frozen", 32'(pmem_addr), 32'd3);
    chk("lin_cnt_hold", 32'(fetch_cnt), 32'd4);

    // Backpressure at if_pc=1
    do_reset();
    tick(); tick();
    id_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_pc",    32'(if_pc), 32'd1);
      chk("bp_instr", if_instr, 32'h8080_0002);
      chk("bp_addr",  32'(pmem_addr), 32'd2);
      chk("bp_cnt",   32'(fetch_cnt), 32'd2);
      chk("bp_valid", 32'(if_valid), 32'd1);
    end
    id_ready = 1'b1;
    tick(); chk("bp_resume_pc", 32'(if_pc), 32'd2); chk("bp_resume_cnt", 32'(fetch_cnt), 32'd3);
    tick(); chk("bp_halt", 32'(halted), 32'd1);

    // Redirect to 4, then flush with target 9 while if_pc=4
    br_valid = 1'b1; br_target = 5'd4;
    tick(); chk("br4_halt", 32'(halted), 32'd0); chk("br4_addr", 32'(pmem_addr), 32'd4);
    br_valid = 1'b0;
    tick(); chk("br4_pc", 32'(if_pc), 32'd4); chk("br4_valid", 32'(if_valid), 32'd1);
    br_valid = 1'b1; br_target = 5'd9;
    tick(); chk("fl_valid", 32'(if_valid), 32'd0); chk("fl_addr", 32'(pmem_addr), 32'd9);
    br_valid = 1'b0;
    tick(); chk("fl_pc9", 32'(if_pc), 32'd9); chk("fl_i9", if_instr, 32'h8000_0009);
    tick(); tick(); tick();
    chk("h12_pc", 32'(if_pc), 32'd12); chk("h12_halt", 32'(halted), 32'd1);

    // Branch out of HALT with id_ready=1 in the same cycle
    br_valid = 1'b1; br_target = 5'd5;
    tick(); chk("bh_halt", 32'(halted), 32'd0); chk("bh_valid", 32'(if_valid), 32'd0);
    chk("bh_addr", 32'(pmem_addr), 32'd5);
    br_valid = 1'b0;
    tick(); chk("bh_pc5", 32'(if_pc), 32'd5); chk("bh_i5", if_instr, 32'h8000_0005);

    // Wrap-around from 30
    br_valid = 1'b1; br_target = 5'd30;
    tick();
    br_valid = 1'b0;
    tick(); chk("wr_30", 32'(if_pc), 32'd30);
    tick(); chk("wr_31", 32'(if_pc), 32'd31);
    tick(); chk("wr_0",  32'(if_pc), 32'd0);
    tick(); chk("wr_1",  32'(if_pc), 32'd1);

    // Asynchronous reset mid-cycle with pc=7, fetch_cnt=7
    mem[3] = 32'h8000_0003;
    do_reset();
    for (int k = 0; k < 7; k++) tick();
    chk("ar_pre_addr",  32'(pmem_addr), 32'd7);
    chk("ar_pre_cnt",   32'(fetch_cnt), 32'd7);
    chk("ar_pre_valid", 32'(if_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(if_valid), 32'd0);
    chk("ar_addr",  32'(pmem_addr), 32'd0);
    chk("ar_cnt",   32'(fetch_cnt), 32'd0);
    chk("ar_halt",  32'(halted), 32'd0);
    tick();
    rst_n = 1'b1;
    tick(); chk("ar_restart", 32'(if_pc), 32'd0); chk("ar_restart_v", 32'(if_valid), 32'd1);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_instr_fetch_unit
`default_nettype wire
